// File: rtl/data_memory.sv
// rtl/data_memory.sv - RV32I data memory with byte-lane stores, extended loads and two MMIO registers
//
// Ports:
//   clk, reset        : single clock, synchronous active-high reset
//   MemRead, MemWrite : load / store strobes for the current cycle
//   funct3            : access size and signedness from the instruction
//   Addr              : byte address (ALU result)
//   WriteData         : store data (rs2)
//   ReadData          : combinational load result, extended to 32 bits
//   Misaligned        : combinational misalignment flag for the current access
//   LedOut            : memory-mapped output register
//   CycleCount        : memory-mapped free-running cycle counter

module data_memory #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Misaligned,
    output logic [31:0] LedOut,
    output logic [31:0] CycleCount
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(4 * DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] led_reg;
    logic [31:0] cycle_count;

    logic          in_ram;
    logic          is_led;
    logic          is_cnt;
    logic          half_acc;
    logic          word_acc;
    logic [AW-1:0] word_idx;
    logic [31:0]   ld_word;
    logic [31:0]   ld_lane;
    logic          store_ok;
    logic [3:0]    wmask;
    logic [31:0]   wdata;

    // Region decode compares the whole address so aliases never hit RAM/MMIO.
    assign in_ram   = {1'b0, Addr} < RAM_BYTES;
    assign is_led   = (Addr == MMIO_BASE);
    assign is_cnt   = (Addr == MMIO_BASE + 32'd4);
    assign word_idx = Addr[AW+1:2];

    assign half_acc = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign word_acc = (funct3 == 3'b010);

    assign Misaligned = (MemRead | MemWrite) &
                        ((half_acc & Addr[0]) | (word_acc & (Addr[1:0] != 2'b00)));

    // Shift the addressed byte/half down to bit 0 so extension works on fixed bits.
    assign ld_word = in_ram ? mem[word_idx] : 32'd0;
    assign ld_lane = ld_word >> {Addr[1:0], 3'b000};

    always_comb begin
        ReadData = 32'd0;
        if (MemRead && !Misaligned) begin
            if (in_ram) begin
                case (funct3)
                    3'b000:  ReadData = {{24{ld_lane[7]}}, ld_lane[7:0]};
                    3'b001:  ReadData = {{16{ld_lane[15]}}, ld_lane[15:0]};
                    3'b010:  ReadData = ld_word;
                    3'b100:  ReadData = {24'd0, ld_lane[7:0]};
                    3'b101:  ReadData = {16'd0, ld_lane[15:0]};
                    default: ReadData = 32'd0;
                endcase
            end else if (is_led && word_acc) begin
                ReadData = led_reg;
            end else if (is_cnt && word_acc) begin
                ReadData = cycle_count;
            end
        end
    end

    // Replicate store data across lanes; the mask picks which lanes commit.
    always_comb begin
        wmask = 4'b0000;
        wdata = WriteData;
        case (funct3)
            3'b000: begin
                wdata = {4{WriteData[7:0]}};
                wmask = 4'b0001 << Addr[1:0];
            end
            3'b001: begin
                wdata = {2{WriteData[15:0]}};
                wmask = Addr[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                wdata = WriteData;
                wmask = 4'b1111;
            end
            default: begin
                wdata = WriteData;
                wmask = 4'b0000;
            end
        endcase
    end

    assign store_ok = MemWrite && !Misaligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < DEPTH_WORDS; w++) begin
                mem[w] <= 32'd0;
            end
            led_reg     <= 32'd0;
            cycle_count <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (store_ok && in_ram) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask[b]) begin
                        mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            if (store_ok && is_led && word_acc) begin
                led_reg <= WriteData;
            end
        end
    end

    assign LedOut     = led_reg;
    assign CycleCount = cycle_count;

endmodule

// File: doc/data_memory.md
# data_memory

Data memory stage directly downstream of the ALU in the single-cycle RISC-V datapath. It takes the ALU `Result` as a byte address and performs RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane writes and sign or zero extension on reads. It also decodes two memory-mapped registers: a writable output register and a free-running cycle counter. Reads are combinational so the single-cycle core completes a load in one cycle; all state updates on the clock edge.

## Interface
- `DEPTH_WORDS`, 256: RAM size in 32-bit words; RAM occupies bytes 0 .. 4*DEPTH_WORDS-1.
- `MMIO_BASE`, 32'h0000_1000: byte address of the output register; the cycle counter is at MMIO_BASE+4.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `MemRead`  in  1  load in this cycle.
- `MemWrite`  in  1  store in this cycle.
- `funct3`  in  3  access size/sign, instruction funct3 field.
- `Addr`  in  32  byte address (ALU Result).
- `WriteData`  in  32  store data (rs2); the low byte/half is used for SB/SH.
- `ReadData`  out  32  load result, extended to 32 bits.
- `Misaligned`  out  1  current access is misaligned.
- `LedOut`  out  32  output register contents.
- `CycleCount`  out  32  cycle counter contents.

## Operation
- Region decode uses the full 32-bit `Addr`:
  - RAM when Addr < 4*DEPTH_WORDS.
  - LED when Addr == MMIO_BASE.
  - CNT when Addr == MMIO_BASE+4.
  - Otherwise unmapped.
- Load formats, by `funct3`:
  - 000 LB: sign-extend the addressed byte.
  - 001 LH: sign-extend the halfword at Addr[1].
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extend.
  - Any other code: ReadData = 0.
- Store formats, by `funct3`:
  - 000 SB: writes WriteData[7:0] to lane Addr[1:0].
  - 001 SH: writes WriteData[15:0] to half Addr[1].
  - 010 SW: writes the full word.
  - Any other code: no write.
- Alignment:
  - `Misaligned` = (MemRead|MemWrite) & ((half access & Addr[0]) | (word access & Addr[1:0]!=0)).
  - Byte accesses are never misaligned.
- A misaligned store writes nothing. A misaligned load returns 0.
- MMIO accesses are word-only:
  - LW at LED returns LedOut; LW at CNT returns CycleCount.
  - Sub-word loads at LED/CNT return 0.
  - SW at LED loads LedOut. Sub-word stores at LED are ignored.
  - Any store to CNT is ignored.
- Unmapped region: loads return 0 and stores are ignored. `Misaligned` is still computed.
- ReadData = 0 whenever MemRead = 0.
- CycleCount increments by 1 on every edge while reset = 0, and wraps 32'hFFFF_FFFF -> 0.

## Timing
- Reset has priority over every write. On an edge with reset = 1:
  - all RAM words are cleared to 0;
  - LedOut = 0;
  - CycleCount = 0;
  - no store takes effect.
- ReadData and Misaligned are combinational; they are zero-latency in the same cycle as Addr/funct3/MemRead.
- Stores commit on the rising edge at the end of the cycle in which MemWrite = 1 and Misaligned = 0. Data is visible to a load in the next cycle.
- MemRead and MemWrite both high to the same address: ReadData shows the pre-store contents in that cycle, and the store commits at the edge.
- CycleCount reads 0 in the first cycle after reset deasserts, then 1, 2, ...
- Reset asserted in the same cycle as a store: the store is dropped and the memory is cleared.

## Test plan
- Reset, then SW 32'hDEADBEEF @0x10, then LW @0x10 -> ReadData 32'hDEADBEEF. LB @0x13 -> 32'hFFFFFFDE. LBU @0x13 -> 32'h000000DE. LH @0x10 -> 32'hFFFFBEEF. LHU @0x12 -> 32'h0000DEAD.
- SB 32'h0000_0055 @0x21 over a word 0x11223344 -> LW @0x20 returns 32'h11225544. SH 32'h0000_AAAA @0x22 -> LW returns 32'hAAAA5544.
- SW @0x06 and SH @0x05 -> Misaligned = 1 and memory unchanged. LW @0x02 -> Misaligned = 1 and ReadData = 0. LB @0x03 -> Misaligned = 0.
- SW 32'h0000_00A5 @MMIO_BASE -> LedOut = 32'hA5 next cycle. SB @MMIO_BASE -> LedOut unchanged. SW @MMIO_BASE+4 -> CycleCount unaffected. LW @MMIO_BASE+4 on the k-th cycle after reset release -> k-1.
- Force the counter near the top (run from reset, or preload in the bench) -> 32'hFFFF_FFFF is followed by 0. Store and load @0x2000 (unmapped) -> no write; ReadData 0.
- Fill RAM, then assert reset for one cycle concurrently with SW @0x0 -> all words read 0, LedOut = 0, CycleCount = 0. Simultaneous MemRead+MemWrite @0x8 -> old value this cycle, new value next cycle.
